// File: rtl/boot_load_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and memory sizing defaults.
package boot_load_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 7;
  localparam int MAX_WORDS  = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_I = 2'd1,
    ST_LOAD_D = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

endpackage

// File: rtl/word_addr_counter.sv
// Write-address counter for one memory; flags the transfer that completes the requested count.
module word_addr_counter
  import boot_load_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              incr,
  input  logic [ADDR_W:0]   target,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] cnt_r;

  // Address register; after word 127 of a full load it wraps to zero, but the FSM has already left the phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (incr) begin
      cnt_r <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign addr = cnt_r;
  assign last = (({1'b0, cnt_r} + {{ADDR_W{1'b0}}, 1'b1}) == target);

endmodule

// File: rtl/boot_load_ctrl.sv
// Boot loader: streams instruction then data words into two memories, then releases the processor.
module boot_load_ctrl
  import boot_load_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic [ADDR_W:0]   imem_count,
  input  logic [ADDR_W:0]   dmem_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instructionAddress,
  output logic              imem_we,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] dataAddress,
  output logic              writeEnable,
  output logic              cpu_run,
  output logic              busy,
  output logic              error
);

  localparam logic [ADDR_W:0] LIMIT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ZERO  = {(ADDR_W+1){1'b0}};

  state_t            state_r;
  logic [ADDR_W:0]   icount_r, dcount_r;
  logic              cpu_run_r, busy_r, error_r;
  logic              imem_we_r, dwe_r;
  logic [DATA_W-1:0] instr_r, data_r;
  logic [ADDR_W-1:0] iaddr_r, daddr_r;

  logic              counts_bad_s, start_ok_s;
  logic              xfer_s, i_xfer_s, d_xfer_s;
  logic [ADDR_W-1:0] i_addr_s, d_addr_s;
  logic              i_last_s, d_last_s;

  assign in_ready     = (state_r == ST_LOAD_I) || (state_r == ST_LOAD_D);
  assign xfer_s       = in_valid && in_ready;
  assign i_xfer_s     = xfer_s && (state_r == ST_LOAD_I);
  assign d_xfer_s     = xfer_s && (state_r == ST_LOAD_D);
  assign counts_bad_s = (imem_count > LIMIT) || (dmem_count > LIMIT);
  assign start_ok_s   = (state_r == ST_IDLE) && start && !counts_bad_s;

  word_addr_counter #(.ADDR_W(ADDR_W)) u_icnt (
    .clk(clk), .rst_n(rst_n), .clear(start_ok_s), .incr(i_xfer_s),
    .target(icount_r), .addr(i_addr_s), .last(i_last_s)
  );

  word_addr_counter #(.ADDR_W(ADDR_W)) u_dcnt (
    .clk(clk), .rst_n(rst_n), .clear(start_ok_s), .incr(d_xfer_s),
    .target(dcount_r), .addr(d_addr_s), .last(d_last_s)
  );

  // Sequencer: phase state plus the status outputs that follow it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      icount_r  <= '0;
      dcount_r  <= '0;
      cpu_run_r <= 1'b0;
      busy_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && counts_bad_s) begin
            error_r <= 1'b1;
          end else if (start) begin
            error_r  <= 1'b0;
            icount_r <= imem_count;
            dcount_r <= dmem_count;
            if (imem_count != ZERO) begin
              state_r <= ST_LOAD_I;
              busy_r  <= 1'b1;
            end else if (dmem_count != ZERO) begin
              state_r <= ST_LOAD_D;
              busy_r  <= 1'b1;
            end else begin
              state_r   <= ST_RUN;
              cpu_run_r <= 1'b1;
            end
          end
        end
        ST_LOAD_I: begin
          if (i_xfer_s && i_last_s) begin
            if (dcount_r != ZERO) begin
              state_r <= ST_LOAD_D;
            end else begin
              state_r   <= ST_RUN;
              busy_r    <= 1'b0;
              cpu_run_r <= 1'b1;
            end
          end
        end
        ST_LOAD_D: begin
          if (d_xfer_s && d_last_s) begin
            state_r   <= ST_RUN;
            busy_r    <= 1'b0;
            cpu_run_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (halt) begin
            state_r   <= ST_IDLE;
            cpu_run_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          cpu_run_r <= 1'b0;
        end
      endcase
    end
  end

  // Memory write ports: one strobe the cycle after each accepted word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we_r <= 1'b0;
      dwe_r     <= 1'b0;
      instr_r   <= '0;
      iaddr_r   <= '0;
      data_r    <= '0;
      daddr_r   <= '0;
    end else begin
      imem_we_r <= i_xfer_s;
      dwe_r     <= d_xfer_s;
      if (i_xfer_s) begin
        instr_r <= in_data;
        iaddr_r <= i_addr_s;
      end
      if (d_xfer_s) begin
        data_r  <= in_data;
        daddr_r <= d_addr_s;
      end
    end
  end

  assign instruction        = instr_r;
  assign instructionAddress = iaddr_r;
  assign imem_we            = imem_we_r;
  assign data               = data_r;
  assign dataAddress        = daddr_r;
  assign writeEnable        = dwe_r;
  assign cpu_run            = cpu_run_r;
  assign busy               = busy_r;
  assign error              = error_r;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Scoreboard bench for boot_load_ctrl: stimulus queues expected memory writes, a negedge monitor checks them.
module tb_boot_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, in_valid;
  logic [7:0]  imem_count, dmem_count;
  logic [31:0] in_data;
  logic        in_ready, imem_we, writeEnable, cpu_run, busy, error;
  logic [31:0] instruction, data;
  logic [6:0]  instructionAddress, dataAddress;

  typedef struct packed {
    logic        is_d;
    logic [6:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  boot_load_ctrl #(.DATA_W(32), .ADDR_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .imem_count(imem_count), .dmem_count(dmem_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .instruction(instruction), .instructionAddress(instructionAddress), .imem_we(imem_we),
    .data(data), .dataAddress(dataAddress), .writeEnable(writeEnable),
    .cpu_run(cpu_run), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest queued write
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (imem_we || writeEnable)) begin
      check("single_strobe", {63'd0, imem_we & writeEnable}, 64'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: imem_we=%0b writeEnable=%0b with nothing queued (t=%0t)",
                 imem_we, writeEnable, $time);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {63'd0, writeEnable}, {63'd0, e.is_d});
        if (writeEnable) begin
          check("dmem_addr", {57'd0, dataAddress}, {57'd0, e.addr});
          check("dmem_data", {32'd0, data}, {32'd0, e.data});
        end else begin
          check("imem_addr", {57'd0, instructionAddress}, {57'd0, e.addr});
          check("imem_data", {32'd0, instruction}, {32'd0, e.data});
        end
      end
    end
  end

  task automatic do_start(input int ni, input int nd);
    imem_count = 8'(ni);
    dmem_count = 8'(nd);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_halt();
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
  endtask

  // Offer one word (after an optional idle gap); queue its expected write at the moment of transfer
  task automatic xfer(input logic [31:0] w, input logic is_d, input int addr, input int gap);
    int n = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      check("ready_during_gap", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: in_ready stayed 0 for word %0h", w);
    end else begin
      exp_q.push_back('{is_d: is_d, addr: 7'(addr), data: w});
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; in_valid = 1'b0;
    in_data = 32'd0; imem_count = 8'd0; dmem_count = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_cpu_run", {63'd0, cpu_run}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_strobes", {62'd0, imem_we, writeEnable}, 64'd0);
    rst_n = 1'b1;
    idle_cycles(1);

    // Program 3 instructions + 2 data words back to back
    do_start(3, 2);
    check("load_busy", {63'd0, busy}, 64'd1);
    check("load_ready", {63'd0, in_ready}, 64'd1);
    check("load_cpu_run", {63'd0, cpu_run}, 64'd0);
    xfer(32'h2022_0003, 1'b0, 0, 0);
    xfer(32'h8C01_0000, 1'b0, 1, 0);
    xfer(32'hAC01_0000, 1'b0, 2, 0);
    xfer(32'd12, 1'b1, 0, 0);
    xfer(32'd34, 1'b1, 1, 0);
    in_valid = 1'b0;
    check("prog_cpu_run", {63'd0, cpu_run}, 64'd1);
    check("prog_busy_done", {63'd0, busy}, 64'd0);
    check("prog_ready_done", {63'd0, in_ready}, 64'd0);
    idle_cycles(2);
    check("prog_all_written", 64'(exp_q.size()), 64'd0);
    do_halt();
    check("halt_cpu_run", {63'd0, cpu_run}, 64'd0);

    // Empty load goes straight to RUN; start ignored in RUN, halt ignored in IDLE
    do_start(0, 0);
    check("empty_cpu_run", {63'd0, cpu_run}, 64'd1);
    check("empty_busy", {63'd0, busy}, 64'd0);
    do_start(2, 2);
    check("start_in_run_ready", {63'd0, in_ready}, 64'd0);
    check("start_in_run_cpu", {63'd0, cpu_run}, 64'd1);
    do_halt();
    check("halt2_cpu_run", {63'd0, cpu_run}, 64'd0);
    do_halt();
    check("halt_idle_ready", {63'd0, in_ready}, 64'd0);
    check("halt_idle_cpu", {63'd0, cpu_run}, 64'd0);

    // Stalled source: valid pattern 1,0,0,1
    do_start(2, 0);
    xfer(32'hCAFE_0001, 1'b0, 0, 0);
    xfer(32'hCAFE_0002, 1'b0, 1, 2);
    in_valid = 1'b0;
    check("stall_cpu_run", {63'd0, cpu_run}, 64'd1);
    idle_cycles(2);
    do_halt();

    // Oversized count flags error; a valid start clears it
    do_start(129, 0);
    check("err_set", {63'd0, error}, 64'd1);
    check("err_ready", {63'd0, in_ready}, 64'd0);
    check("err_busy", {63'd0, busy}, 64'd0);
    check("err_cpu_run", {63'd0, cpu_run}, 64'd0);
    do_start(0, 200);
    check("err_sticky", {63'd0, error}, 64'd1);
    do_start(0, 0);
    check("err_cleared", {63'd0, error}, 64'd0);
    check("err_then_run", {63'd0, cpu_run}, 64'd1);
    do_halt();

    // Full data memory: 128 words at addresses 0..127
    do_start(0, 128);
    for (int k = 0; k < 128; k++) begin
      xfer(32'hD000_0000 + 32'(k), 1'b1, k, 0);
    end
    in_valid = 1'b0;
    check("full_cpu_run", {63'd0, cpu_run}, 64'd1);
    check("full_busy", {63'd0, busy}, 64'd0);
    idle_cycles(3);
    check("full_all_written", 64'(exp_q.size()), 64'd0);
    do_halt();

    // Reset in the middle of a 5-word load
    do_start(5, 0);
    xfer(32'h1111_0000, 1'b0, 0, 0);
    xfer(32'h1111_0001, 1'b0, 1, 0);
    in_valid = 1'b0;
    @(posedge clk); #3;
    in_valid = 1'b1;
    in_data  = 32'h1111_0002;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_ready", {63'd0, in_ready}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_strobes", {62'd0, imem_we, writeEnable}, 64'd0);
    check("mid_rst_iaddr", {57'd0, instructionAddress}, 64'd0);
    check("mid_rst_instr", {32'd0, instruction}, 64'd0);
    check("mid_rst_data", {32'd0, data}, 64'd0);
    check("mid_rst_daddr", {57'd0, dataAddress}, 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_strobes", {62'd0, imem_we, writeEnable}, 64'd0);
    check("post_rst_ready", {63'd0, in_ready}, 64'd0);
    do_start(2, 1);
    xfer(32'h2222_0000, 1'b0, 0, 0);
    xfer(32'h2222_0001, 1'b0, 1, 0);
    xfer(32'h3333_0000, 1'b1, 0, 0);
    in_valid = 1'b0;
    check("restart_cpu_run", {63'd0, cpu_run}, 64'd1);
    idle_cycles(3);
    do_halt();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
